uart_rgb_ctrl: RTL and testbench

Parametrised UART-command LED controller: parses an ASCII command byte stream and drives NUM_CH independent 8-bit PWM outputs. It replaces fixed on/off colour decoding with per-channel brightness, hex frames, status readback and an inter-byte timeout. It sits between the UART byte interface (via a thin simpleuart adapter in the top level) and the SB_RGBA_DRV PWM inputs.

---
 rtl/rgb_ctrl_pkg.sv | 70 +++++++
 rtl/pwm_bank.sv | 81 ++++++++
 rtl/uart_rgb_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rgb_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_ctrl_pkg.sv
// Shared constants, state encoding and helper functions for the UART RGB controller.
// Gamma correction is selected at build time by RGB_CTRL_GAMMA_EN (see pwm_bank).
package rgb_ctrl_pkg;

    localparam logic [7:0] ASCII_P     = 8'h50;
    localparam logic [7:0] ASCII_K     = 8'h4B;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_HASH  = 8'h23;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_7     = 8'h37;

    typedef enum logic [2:0] {
        ST_BANNER = 3'd0,
        ST_IDLE   = 3'd1,
        ST_HEX    = 3'd2,
        ST_SEND   = 3'd3,
        ST_QUERY  = 3'd4
    } state_t;

    function automatic logic is_hex(input logic [7:0] b);
        logic r;
        if (b >= 8'h30 && b <= 8'h39) begin
            r = 1'b1;
        end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            r = 1'b1;
        end else begin
            r = 1'b0;
        end
        return r;
    endfunction

    // Letters of either case share the low nibble 1..6, so +9 gives 10..15.
    function automatic logic [3:0] hex_to_nib(input logic [7:0] b);
        logic [3:0] r;
        if (b >= 8'h30 && b <= 8'h39) begin
            r = b[3:0];
        end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
            r = b[3:0] + 4'd9;
        end else begin
            r = 4'h0;
        end
        return r;
    endfunction

    function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
        logic [7:0] r;
        if (n < 4'd10) begin
            r = 8'h30 + {4'h0, n};
        end else begin
            r = 8'h37 + {4'h0, n};
        end
        return r;
    endfunction

    function automatic logic [7:0] gamma_map(input logic [7:0] d);
        logic [15:0] p;
        logic [7:0]  r;
        p = {8'h00, d} * {8'h00, d};
        if (d == 8'hFF) begin
            r = 8'hFF;
        end else begin
            r = p[15:8];
        end
        return r;
    endfunction

endpackage

// File: rtl/pwm_bank.sv
// Prescaled 255-step PWM for NUM_CH channels with shadow-to-active duty load at period wrap.
// With RGB_CTRL_GAMMA_EN defined the compare uses the squared (gamma) duty.
module pwm_bank
    import rgb_ctrl_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int PRESCALE = 47
) (
    input  logic                  hw_clk,
    input  logic                  reset,
    input  logic [8*NUM_CH-1:0]   shadow_duty,
    input  logic                  load,
    output logic [8*NUM_CH-1:0]   active_duty,
    output logic [NUM_CH-1:0]     pwm_out
);

    localparam int DW = 8 * NUM_CH;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);

    logic [PW-1:0]     presc_r;
    logic [7:0]        pwm_cnt_r;
    logic              pending_r;
    logic [DW-1:0]     active_r;
    logic [NUM_CH-1:0] pwm_out_r;
    logic              tick_s;
    logic              wrap_s;
    logic [DW-1:0]     duty_eff_s;
    logic [NUM_CH-1:0] pwm_cmp_s;

    // Tick and period-wrap strobes
    always_comb begin
        tick_s = (presc_r == PRESC_MAX);
        wrap_s = tick_s && (pwm_cnt_r == 8'd254);
    end

    // Effective duty and per-channel compare
    always_comb begin
        duty_eff_s = {DW{1'b0}};
        pwm_cmp_s  = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef RGB_CTRL_GAMMA_EN
            duty_eff_s[i*8 +: 8] = gamma_map(active_r[i*8 +: 8]);
`else
            duty_eff_s[i*8 +: 8] = active_r[i*8 +: 8];
`endif
            pwm_cmp_s[i] = (pwm_cnt_r < duty_eff_s[i*8 +: 8]);
        end
    end

    // Counters, pending-load flag, active duties and registered outputs
    always_ff @(posedge hw_clk) begin
        if (reset) begin
            presc_r   <= {PW{1'b0}};
            pwm_cnt_r <= 8'd0;
            pending_r <= 1'b0;
            active_r  <= {DW{1'b0}};
            pwm_out_r <= {NUM_CH{1'b0}};
        end else begin
            presc_r <= tick_s ? {PW{1'b0}} : (presc_r + PRESC_ONE);
            if (tick_s) begin
                pwm_cnt_r <= wrap_s ? 8'd0 : (pwm_cnt_r + 8'd1);
            end
            // A load arriving on the wrap cycle itself is taken immediately.
            if (wrap_s) begin
                if (pending_r || load) begin
                    active_r <= shadow_duty;
                end
                pending_r <= 1'b0;
            end else if (load) begin
                pending_r <= 1'b1;
            end
            pwm_out_r <= pwm_cmp_s;
        end
    end

    assign active_duty = active_r;
    assign pwm_out     = pwm_out_r;

endmodule

// File: rtl/uart_rgb_ctrl.sv
// ASCII command parser driving a bank of PWM channels; replies on a byte stream.
// Optional gamma correction on the PWM path: define RGB_CTRL_GAMMA_EN.
module uart_rgb_ctrl
    import rgb_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int PRESCALE    = 47,
    parameter int TIMEOUT_CYC = 1200000
) (
    input  logic              hw_clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam int DW = 8 * NUM_CH;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);
    localparam logic [4:0]    DIG_LAST = 5'(2 * NUM_CH - 1);
    localparam logic [4:0]    QIDX_CR  = 5'(2 * NUM_CH);
    localparam logic [4:0]    QIDX_LF  = 5'(2 * NUM_CH + 1);

    state_t        state_r, state_s;
    logic          rx_ready_r, rx_ready_s;
    logic          tx_valid_r, tx_valid_s;
    logic [7:0]    tx_data_r, tx_data_s;
    logic [4:0]    dig_cnt_r, dig_cnt_s;
    logic [TW-1:0] to_cnt_r, to_cnt_s;
    logic [DW-1:0] staging_r, staging_s;
    logic [DW-1:0] shadow_r, shadow_s;
    logic          load_r, load_s;
    logic [DW-1:0] qbuf_r, qbuf_s;
    logic [4:0]    qidx_r, qidx_s;
    logic          rx_hs_s;
    logic          tx_hs_s;
    logic [DW-1:0] active_s;

    pwm_bank #(
        .NUM_CH   (NUM_CH),
        .PRESCALE (PRESCALE)
    ) u_pwm_bank (
        .hw_clk      (hw_clk),
        .reset       (reset),
        .shadow_duty (shadow_r),
        .load        (load_r),
        .active_duty (active_s),
        .pwm_out     (pwm_out)
    );

    // Parser next-state and output logic
    always_comb begin
        state_s   = state_r;
        tx_valid_s = tx_valid_r;
        tx_data_s = tx_data_r;
        dig_cnt_s = dig_cnt_r;
        to_cnt_s  = to_cnt_r;
        staging_s = staging_r;
        shadow_s  = shadow_r;
        load_s    = 1'b0;
        qbuf_s    = qbuf_r;
        qidx_s    = qidx_r;
        rx_hs_s   = rx_valid && rx_ready_r;
        tx_hs_s   = tx_valid_r && tx_ready;

        case (state_r)
            ST_BANNER: begin
                tx_valid_s = 1'b1;
                tx_data_s  = ASCII_P;
                state_s    = ST_SEND;
            end
            ST_SEND: begin
                if (tx_hs_s) begin
                    tx_valid_s = 1'b0;
                    state_s    = ST_IDLE;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_IDLE: begin
                if (rx_hs_s) begin
                    if (rx_data >= ASCII_0 && rx_data <= ASCII_7) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            shadow_s[i*8 +: 8] = (i < 3 && rx_data[i]) ? 8'hFF : 8'h00;
                        end
                        load_s     = 1'b1;
                        tx_valid_s = 1'b1;
                        tx_data_s  = ASCII_K;
                        state_s    = ST_SEND;
                    end else if (rx_data == ASCII_HASH) begin
                        dig_cnt_s = 5'd0;
                        to_cnt_s  = {TW{1'b0}};
                        state_s   = ST_HEX;
                    end else if (rx_data == ASCII_QMARK) begin
                        // Snapshot with channel 0 in the top byte so digits shift out MSB first.
                        for (int i = 0; i < NUM_CH; i++) begin
                            qbuf_s[(NUM_CH-1-i)*8 +: 8] = active_s[i*8 +: 8];
                        end
                        qidx_s     = 5'd0;
                        tx_valid_s = 1'b1;
                        tx_data_s  = nib_to_ascii(active_s[7:4]);
                        state_s    = ST_QUERY;
                    end else if (rx_data == ASCII_CR || rx_data == ASCII_LF) begin
                        state_s = ST_IDLE;
                    end else begin
                        tx_valid_s = 1'b1;
                        tx_data_s  = ASCII_E;
                        state_s    = ST_SEND;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HEX: begin
                if (rx_hs_s) begin
                    to_cnt_s = {TW{1'b0}};
                    if (is_hex(rx_data)) begin
                        staging_s = {staging_r[DW-5:0], hex_to_nib(rx_data)};
                        if (dig_cnt_r == DIG_LAST) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                shadow_s[i*8 +: 8] = staging_s[(NUM_CH-1-i)*8 +: 8];
                            end
                            load_s     = 1'b1;
                            tx_valid_s = 1'b1;
                            tx_data_s  = ASCII_K;
                            state_s    = ST_SEND;
                        end else begin
                            dig_cnt_s = dig_cnt_r + 5'd1;
                        end
                    end else begin
                        tx_valid_s = 1'b1;
                        tx_data_s  = ASCII_E;
                        state_s    = ST_SEND;
                    end
                end else if (to_cnt_r == TO_LAST) begin
                    tx_valid_s = 1'b1;
                    tx_data_s  = ASCII_E;
                    state_s    = ST_SEND;
                end else begin
                    to_cnt_s = to_cnt_r + TO_ONE;
                end
            end
            ST_QUERY: begin
                if (tx_hs_s) begin
                    if (qidx_r == QIDX_LF) begin
                        tx_valid_s = 1'b0;
                        state_s    = ST_IDLE;
                    end else begin
                        qidx_s = qidx_r + 5'd1;
                        if (qidx_s < QIDX_CR) begin
                            qbuf_s    = qbuf_r << 3'd4;
                            tx_data_s = nib_to_ascii(qbuf_s[DW-1 -: 4]);
                        end else if (qidx_s == QIDX_CR) begin
                            tx_data_s = ASCII_CR;
                        end else begin
                            tx_data_s = ASCII_LF;
                        end
                    end
                end else begin
                    state_s = ST_QUERY;
                end
            end
            default: begin
                tx_valid_s = 1'b0;
                state_s    = ST_BANNER;
            end
        endcase

        rx_ready_s = (state_s == ST_IDLE) || (state_s == ST_HEX);
    end

    // Parser state and registered outputs
    always_ff @(posedge hw_clk) begin
        if (reset) begin
            state_r    <= ST_BANNER;
            rx_ready_r <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            dig_cnt_r  <= 5'd0;
            to_cnt_r   <= {TW{1'b0}};
            staging_r  <= {DW{1'b0}};
            shadow_r   <= {DW{1'b0}};
            load_r     <= 1'b0;
            qbuf_r     <= {DW{1'b0}};
            qidx_r     <= 5'd0;
        end else begin
            state_r    <= state_s;
            rx_ready_r <= rx_ready_s;
            tx_valid_r <= tx_valid_s;
            tx_data_r  <= tx_data_s;
            dig_cnt_r  <= dig_cnt_s;
            to_cnt_r   <= to_cnt_s;
            staging_r  <= staging_s;
            shadow_r   <= shadow_s;
            load_r     <= load_s;
            qbuf_r     <= qbuf_s;
            qidx_r     <= qidx_s;
        end
    end

    assign rx_ready = rx_ready_r;
    assign tx_valid = tx_valid_r;
    assign tx_data  = tx_data_r;

endmodule

// File: tb/tb_uart_rgb_ctrl.sv
// Scoreboard bench: a command-level model predicts reply bytes and PWM duty per channel.
module tb_uart_rgb_ctrl;

    localparam int NUM_CH      = 3;
    localparam int PRESCALE    = 1;
    localparam int TIMEOUT_CYC = 40;
    localparam int PERIOD      = 255 * PRESCALE;

    logic              hw_clk;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [NUM_CH-1:0] pwm_out;

    uart_rgb_ctrl #(
        .NUM_CH      (NUM_CH),
        .PRESCALE    (PRESCALE),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .hw_clk   (hw_clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .pwm_out  (pwm_out)
    );

    initial begin
        hw_clk = 1'b0;
        forever #5 hw_clk = ~hw_clk;
    end

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    bit         hold_tx = 1'b0;

    // reference model state
    int m_duty[NUM_CH];
    bit m_in_frame;
    int m_ndig;
    int m_nib[2*NUM_CH];
    bit m_committed;

    function automatic int hexval(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 65 + 10;
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 97 + 10;
        return -1;
    endfunction

    function automatic logic [7:0] hexchar(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    function automatic int eff_duty(input int d);
`ifdef RGB_CTRL_GAMMA_EN
        return (d == 255) ? 255 : (d * d) / 256;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) m_duty[i] = 0;
        m_in_frame  = 1'b0;
        m_ndig      = 0;
        m_committed = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int v;
        v = hexval(b);
        if (m_in_frame) begin
            if (v >= 0) begin
                m_nib[m_ndig] = v;
                m_ndig++;
                if (m_ndig == 2 * NUM_CH) begin
                    for (int i = 0; i < NUM_CH; i++) m_duty[i] = m_nib[2*i] * 16 + m_nib[2*i+1];
                    exp_q.push_back(8'h4B);
                    m_in_frame  = 1'b0;
                    m_committed = 1'b1;
                end
            end else begin
                exp_q.push_back(8'h45);
                m_in_frame = 1'b0;
            end
        end else if (b >= 8'h30 && b <= 8'h37) begin
            for (int i = 0; i < NUM_CH; i++)
                m_duty[i] = (i < 3 && (((int'(b) - 48) >> i) & 1) == 1) ? 255 : 0;
            exp_q.push_back(8'h4B);
            m_committed = 1'b1;
        end else if (b == 8'h23) begin
            m_in_frame = 1'b1;
            m_ndig     = 0;
        end else if (b == 8'h3F) begin
            for (int i = 0; i < NUM_CH; i++) begin
                exp_q.push_back(hexchar(m_duty[i] / 16));
                exp_q.push_back(hexchar(m_duty[i] % 16));
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end else if (b == 8'h0D || b == 8'h0A) begin
            m_committed = m_committed;
        end else begin
            exp_q.push_back(8'h45);
        end
    endtask

    // tx backpressure
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge hw_clk);
            #1;
            tx_ready = hold_tx ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // monitor: pops the scoreboard on every accepted tx byte
    logic       prev_pend = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_b;
    always @(negedge hw_clk) begin
        if (reset) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                vectors++;
                if (!(tx_valid && tx_data == prev_data)) begin
                    miscompares++;
                    $display("FAIL tx_hold: valid=%0b data=%02h, required valid=1 data=%02h", tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid) begin
                vectors++;
                if (rx_ready) begin
                    miscompares++;
                    $display("FAIL rx_ready_busy: rx_ready=1 while tx_valid=1, required 0");
                end
            end
            if (tx_valid && tx_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL tx_unexpected: got byte %02h, required no byte", tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (tx_data !== exp_b) begin
                        miscompares++;
                        $display("FAIL tx_byte: got %02h, required %02h", tx_data, exp_b);
                    end
                end
            end
            prev_pend = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(posedge hw_clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        model_byte(b);
        forever begin
            @(negedge hw_clk);
            if (rx_ready) break;
            n++;
            if (n > 3000) begin
                vectors++;
                miscompares++;
                $display("FAIL rx_accept_timeout: byte %02h not accepted, required acceptance", b);
                break;
            end
        end
        @(posedge hw_clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_valid) && n < 3000) begin
            @(negedge hw_clk);
            n++;
        end
        if (n >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d bytes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic check_pwm(input string tag);
        int cnt[NUM_CH];
        repeat (PERIOD + 5) @(negedge hw_clk);
        for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
        repeat (PERIOD) begin
            @(negedge hw_clk);
            for (int i = 0; i < NUM_CH; i++) if (pwm_out[i]) cnt[i]++;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            vectors++;
            if (cnt[i] != eff_duty(m_duty[i])) begin
                miscompares++;
                $display("FAIL pwm_%s ch%0d: high %0d/255, required %0d/255", tag, i, cnt[i], eff_duty(m_duty[i]));
            end
        end
        m_committed = 1'b0;
    endtask

    task automatic reset_dut();
        reset    = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(posedge hw_clk);
        @(negedge hw_clk);
        vectors++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b0 || tx_data !== 8'h00 || pwm_out !== '0) begin
            miscompares++;
            $display("FAIL reset_state: tx_valid=%0b rx_ready=%0b tx_data=%02h pwm=%b, required 0/0/00/0",
                     tx_valid, rx_ready, tx_data, pwm_out);
        end
        exp_q.delete();
        model_reset();
        exp_q.push_back(8'h50);
        @(posedge hw_clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         quiet;
        int         kind;
        int         v;
        logic [7:0] b;

        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        model_reset();

        reset_dut();
        drain();
        check_pwm("reset");

        send_byte(8'h35);
        drain();
        check_pwm("five");

        send_str("#FF8000");
        drain();
        check_pwm("ff8000");
        send_byte(8'h3F);
        drain();

        send_str("#12G");
        drain();
        send_byte(8'h3F);
        drain();

        // inter-byte timeout inside a frame
        send_str("#12");
        quiet = 1'b1;
        repeat (TIMEOUT_CYC - 5) begin
            @(negedge hw_clk);
            if (tx_valid) quiet = 1'b0;
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL timeout_early: reply before %0d idle cycles, required none", TIMEOUT_CYC - 5);
        end
        exp_q.push_back(8'h45);
        m_in_frame = 1'b0;
        repeat (20) @(negedge hw_clk);
        drain();
        send_byte(8'h33);
        drain();
        check_pwm("three");

        // long backpressure during a query reply
        send_byte(8'h3F);
        hold_tx = 1'b1;
        repeat (100) @(negedge hw_clk);
        hold_tx = 1'b0;
        drain();

        // reset in the middle of a frame
        send_str("#A");
        reset_dut();
        drain();
        send_byte(8'h3F);
        drain();
        check_pwm("after_reset");

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: send_byte(8'(48 + $urandom_range(0, 7)));
                1: begin
                    send_byte(8'h23);
                    for (int d = 0; d < 2 * NUM_CH; d++) begin
                        v = $urandom_range(0, 15);
                        if (v >= 10 && $urandom_range(0, 1) == 1) send_byte(8'(97 + v - 10));
                        else send_byte(hexchar(v));
                    end
                end
                2: begin
                    send_byte(8'h23);
                    for (int d = 0; d < $urandom_range(0, 2 * NUM_CH - 1); d++) send_byte(hexchar($urandom_range(0, 15)));
                    b = 8'($urandom_range(0, 255));
                    while (hexval(b) >= 0) b = 8'($urandom_range(0, 255));
                    send_byte(b);
                end
                3: send_byte(8'h3F);
                4: begin
                    b = 8'($urandom_range(0, 255));
                    while (b == 8'h23) b = 8'($urandom_range(0, 255));
                    send_byte(b);
                end
                default: send_byte(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
            endcase
            drain();
            if (m_committed) check_pwm("random");
        end

        repeat (20) @(negedge hw_clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: %0d bytes outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
